// File: rtl/jtmx5k_sndcmd.sv
// jtmx5k_sndcmd: main-CPU sound command FIFO driving snd_latch with IRQ pulse and read/timeout handshake
module jtmx5k_sndcmd #(
  parameter int FIFO_AW = 2,
  parameter int IRQ_LEN = 16,
  parameter int TMO_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       wr_n,
  input  logic [7:0] din,
  input  logic       snd_rd,
  output logic [7:0] snd_latch,
  output logic       snd_irq,
  output logic       full,
  output logic       busy,
  output logic       ovf
);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;
  state_t st_q, st_d;
  logic [7:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0] count_q, count_d;
  logic [7:0] irq_cnt_q, irq_cnt_d, latch_q, latch_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic wr_prev_q, rd_prev_q, ack_seen_q, ack_seen_d, irq_q, irq_d, ovf_q, ovf_d;
  logic wr_act, push, ack, empty, pop, push_ok;
  always_comb begin
    wr_act   = cs & ~wr_n;
    push     = wr_act & ~wr_prev_q;
    ack      = snd_rd & ~rd_prev_q;
    empty    = count_q == '0;
    full     = count_q == (FIFO_AW+1)'(DEPTH);
    pop      = (st_q == IDLE) & ~empty;
    push_ok  = push & (~full | pop);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop);
    ovf_d    = ovf_q | (push & full & ~pop);
    busy     = ~empty | (st_q != IDLE);
  end
  always_comb begin
    st_d       = st_q;
    latch_d    = latch_q;
    irq_d      = irq_q;
    irq_cnt_d  = irq_cnt_q;
    tmo_d      = tmo_q;
    ack_seen_d = ack_seen_q;
    case (st_q)
      IDLE: if (!empty) begin
        latch_d    = mem_q[rd_ptr_q];
        irq_d      = 1'b1;
        irq_cnt_d  = 8'(IRQ_LEN - 1);
        ack_seen_d = 1'b0;
        st_d       = PULSE;
      end
      PULSE: begin
        ack_seen_d = ack_seen_q | ack;
        irq_cnt_d  = irq_cnt_q - 8'd1;
        if (irq_cnt_q == 8'd0) begin
          irq_cnt_d = irq_cnt_q;
          irq_d     = 1'b0;
          tmo_d     = '0;
          st_d      = WAIT;
        end
      end
      WAIT: begin
        // an unacknowledged byte is abandoned once the timeout saturates
        tmo_d = tmo_q + 1'b1;
        if (ack_seen_q | ack) begin
          ack_seen_d = 1'b0;
          st_d       = IDLE;
        end else if (&tmo_q) begin
          tmo_d = tmo_q;
          st_d  = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_ptr_q] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      irq_cnt_q  <= '0;
      latch_q    <= '0;
      tmo_q      <= '0;
      wr_prev_q  <= 1'b0;
      rd_prev_q  <= 1'b0;
      ack_seen_q <= 1'b0;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      irq_cnt_q  <= irq_cnt_d;
      latch_q    <= latch_d;
      tmo_q      <= tmo_d;
      wr_prev_q  <= wr_act;
      rd_prev_q  <= snd_rd;
      ack_seen_q <= ack_seen_d;
      irq_q      <= irq_d;
      ovf_q      <= ovf_d;
    end
  end
  assign snd_latch = latch_q;
  assign snd_irq   = irq_q;
  assign ovf       = ovf_q;
endmodule
